ws2812b_bit_encoder: RTL

Downstream line encoder for the TinyQV WS2812B LED-strip peripheral. It accepts 24-bit GRB pixel words from the register-level driver over a valid/ready/latch handshake and serialises them MSB-first onto the single-wire WS2812B protocol. A one-pixel holding register double-buffers the shifter, so back-to-back pixels leave no gap on the line. A pixel tagged with latch is followed by the strip reset/latch low period.

---
 rtl/ws2812b_bit_encoder_if.sv | 10 +
 rtl/ws2812b_bit_encoder.sv | 128 ++++++++++++
 2 files changed

// File: rtl/ws2812b_bit_encoder_if.sv
// Pixel handshake between the register-level driver (master) and the WS2812B line encoder (slave).
interface ws2812b_bit_encoder_if;
    logic [23:0] data_in;
    logic        valid;
    logic        latch;
    logic        ready;

    modport master (output data_in, valid, latch, input ready);
    modport slave  (input data_in, valid, latch, output ready);
endinterface

// File: rtl/ws2812b_bit_encoder.sv
// Serialises 24-bit GRB pixels MSB-first onto the WS2812B line; led rises 2 cycles after an idle accept.
// One-pixel holding register keeps the line seamless; ready (= holding register empty) is the only backpressure.
module ws2812b_bit_encoder #(
    parameter int T0H  = 26,
    parameter int T1H  = 51,
    parameter int TBIT = 80,
    parameter int TRES = 19200
) (
    input  logic                 clk,
    input  logic                 reset,
    ws2812b_bit_encoder_if.slave bus,
    output logic                 led,
    output logic                 idle
);
    localparam int TW = $clog2(TRES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW,
        S_RES
    } state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [4:0]    bit_cnt, bit_cnt_nxt;
    logic [23:0]   shreg, shreg_nxt;
    logic          sh_latch, sh_latch_nxt;

    logic [23:0]   hold_data;
    logic          hold_latch;
    logic          full;
    logic          full_nxt;
    logic          accept;
    logic          unload;
    logic [TW-1:0] t_high_end;

    assign accept     = bus.valid & bus.ready;
    // Unload reads the old holding contents, so a same-cycle accept simply refills it.
    assign full_nxt   = accept | (full & ~unload);
    assign t_high_end = shreg[23] ? TW'(T1H - 1) : TW'(T0H - 1);

    always_comb begin
        state_nxt    = state;
        timer_nxt    = timer + TW'(1);
        bit_cnt_nxt  = bit_cnt;
        shreg_nxt    = shreg;
        sh_latch_nxt = sh_latch;
        unload       = 1'b0;

        case (state)
            S_IDLE: begin
                timer_nxt = '0;
                if (full) begin
                    unload    = 1'b1;
                    state_nxt = S_HIGH;
                end
            end
            S_HIGH: begin
                if (timer == t_high_end) state_nxt = S_LOW;
            end
            S_LOW: begin
                if (timer == TW'(TBIT - 1)) begin
                    timer_nxt = '0;
                    if (bit_cnt != 5'd0) begin
                        bit_cnt_nxt = bit_cnt - 5'd1;
                        shreg_nxt   = {shreg[22:0], 1'b0};
                        state_nxt   = S_HIGH;
                    end else if (sh_latch) begin
                        state_nxt = S_RES;
                    end else if (full) begin
                        unload    = 1'b1;
                        state_nxt = S_HIGH;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_RES: begin
                if (timer == TW'(TRES - 1)) begin
                    timer_nxt = '0;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                timer_nxt = '0;
                state_nxt = S_RES;
            end
        endcase

        if (unload) begin
            shreg_nxt    = hold_data;
            sh_latch_nxt = hold_latch;
            bit_cnt_nxt  = 5'd23;
        end
    end

    // Reset lands in RES so the strip always gets a full latch period, even mid-pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_RES;
            timer      <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            sh_latch   <= 1'b0;
            hold_data  <= '0;
            hold_latch <= 1'b0;
            full       <= 1'b0;
            bus.ready  <= 1'b1;
            led        <= 1'b0;
            idle       <= 1'b0;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shreg    <= shreg_nxt;
            sh_latch <= sh_latch_nxt;
            if (accept) begin
                hold_data  <= bus.data_in;
                hold_latch <= bus.latch;
            end
            full      <= full_nxt;
            bus.ready <= ~full_nxt;
            led       <= (state_nxt == S_HIGH);
            idle      <= (state_nxt == S_IDLE) && !full_nxt;
        end
    end
endmodule
